// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes and datapath selects.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_HALT     = 4'd15
  } state_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} imm_src_e;
  typedef enum logic [1:0] {SRCA_RS1 = 2'b00, SRCA_PC = 2'b01, SRCA_OLDPC = 2'b10} alu_src_a_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEMDATA = 2'b01, RES_ALU = 2'b10} result_src_e;

  // Immediate format the decoder should present while the opcode is in DECODE.
  function automatic imm_src_e decode_imm_src(input logic [6:0] opcode);
    case (opcode)
      OP_IMM:  return IMM_I;
      STORE:   return IMM_S;
      BRANCH:  return IMM_B;
      default: return IMM_J;
    endcase
  endfunction

endpackage

// File: rtl/m_mc_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the shared datapath.
// Latency: none (wires only).
// Backpressure: memory request is held by the controller until the datapath pulses ack.
interface m_mc_ctrl_if;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic        w_branch_taken;
  logic        w_mem_ack;
  logic        w_pc_we;
  logic        w_ir_we;
  logic        w_rf_we;
  logic        w_mem_req;
  logic        w_mem_we;
  logic [1:0]  w_imm_src;
  logic [1:0]  w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_alu_op;
  logic [1:0]  w_result_src;
  logic [3:0]  w_state;
  logic        w_halt;
  logic        w_err;
  logic [31:0] w_retire_cnt;

  modport master (
    input  w_opcode, w_rd, w_branch_taken, w_mem_ack,
    output w_pc_we, w_ir_we, w_rf_we, w_mem_req, w_mem_we,
           w_imm_src, w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src,
           w_state, w_halt, w_err, w_retire_cnt
  );

  modport slave (
    output w_opcode, w_rd, w_branch_taken, w_mem_ack,
    input  w_pc_we, w_ir_we, w_rf_we, w_mem_req, w_mem_we,
           w_imm_src, w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src,
           w_state, w_halt, w_err, w_retire_cnt
  );
endinterface

// File: rtl/m_mem_wait_timer.sv
// Counts cycles a memory request has waited and flags the last allowed unacked cycle.
// Latency: timeout is combinational from the registered count and the current ack.
// Backpressure: none; ack in the final cycle suppresses timeout.
module m_mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic w_clk,
  input  logic w_rst,
  input  logic w_active,
  input  logic w_ack,
  output logic w_timeout
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  // Count holds the number of earlier unacked cycles in this wait.
  logic [7:0] cnt;

  // Clear on reset, ack or leaving the wait state; otherwise count up, saturating.
  always_ff @(posedge w_clk) begin
    if (w_rst || !w_active || w_ack) begin
      cnt <= 8'd0;
    end else if (cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
    end
  end

  // This cycle is the LIMIT-th unacked one: give up unless ack arrives now.
  always_comb begin
    w_timeout = w_active && !w_ack && (cnt >= LAST);
  end

endmodule

// File: rtl/m_mc_ctrl.sv
// Multi-cycle FSM sequencing PC/IR/regfile/ALU/memory with retire count and halt/error.
// Latency: 3-5 cycles per instruction plus memory wait; outputs are Moore on the state.
// Backpressure: MEMREAD/MEMWRITE hold mem_req until ack; MEM_TIMEOUT unacked cycles error-halt.
module m_mc_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int HALT_REG    = 30
) (
  input  logic     w_clk,
  input  logic     w_rst,
  m_mc_ctrl_if.master bus
);

  localparam logic [4:0] HALT_RD = HALT_REG[4:0];

  state_e      state_q;
  state_e      state_d;
  logic        err_q;
  logic        err_set;
  logic        retire;
  logic [31:0] retire_cnt_q;
  logic        mem_active;
  logic        mem_timeout;

  logic        pc_we, ir_we, rf_we, mem_req, mem_we;
  imm_src_e    imm_src;
  alu_src_a_e  alu_src_a;
  alu_src_b_e  alu_src_b;
  alu_op_e     alu_op;
  result_src_e result_src;

  assign mem_active = (state_q == ST_MEMREAD) || (state_q == ST_MEMWRITE);

  m_mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .w_active  (mem_active),
    .w_ack     (bus.w_mem_ack),
    .w_timeout (mem_timeout)
  );

  // State register; reset lands in FETCH.
  always_ff @(posedge w_clk) begin
    if (w_rst) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Error flag is latched on the transition into HALT and held until reset.
  always_ff @(posedge w_clk) begin
    if (w_rst)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  // Retired instruction counter, wraps naturally at 2^32.
  always_ff @(posedge w_clk) begin
    if (w_rst)       retire_cnt_q <= 32'd0;
    else if (retire) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d    = state_q;
    err_set    = 1'b0;
    retire     = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    imm_src    = IMM_I;
    alu_src_a  = SRCA_RS1;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;

    case (state_q)
      ST_FETCH: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        state_d    = ST_DECODE;
      end
      ST_DECODE: begin
        // ALUOut captures old PC + imm as the branch/jump target.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = decode_imm_src(bus.w_opcode);
        case (bus.w_opcode)
          LOAD, STORE: state_d = ST_MEMADR;
          OP:          state_d = ST_EXECR;
          OP_IMM:      state_d = ST_EXECI;
          BRANCH:      state_d = ST_BRANCH;
          JAL:         state_d = ST_JAL;
          default: begin
            state_d = ST_HALT;
            err_set = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_b = SRCB_IMM;
        imm_src   = (bus.w_opcode == STORE) ? IMM_S : IMM_I;
        state_d   = (bus.w_opcode == STORE) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        if (bus.w_mem_ack) begin
          state_d = ST_MEMWB;
        end else if (mem_timeout) begin
          state_d = ST_HALT;
          err_set = 1'b1;
        end
      end
      ST_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (bus.w_mem_ack) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (mem_timeout) begin
          state_d = ST_HALT;
          err_set = 1'b1;
        end
      end
      ST_MEMWB: begin
        rf_we      = 1'b1;
        result_src = RES_MEMDATA;
        retire     = 1'b1;
        state_d    = (bus.w_rd == HALT_RD) ? ST_HALT : ST_FETCH;
      end
      ST_EXECR: begin
        alu_op  = ALU_FUNCT;
        state_d = ST_ALUWB;
      end
      ST_EXECI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = ST_ALUWB;
      end
      ST_ALUWB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = (bus.w_rd == HALT_RD) ? ST_HALT : ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op  = ALU_SUB;
        pc_we   = bus.w_branch_taken;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_JAL: begin
        // PC takes the target from ALUOut; ALUWB then writes the link value.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_we     = 1'b1;
        state_d   = ST_ALUWB;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
        err_set = 1'b1;
      end
    endcase
  end

  // Reset forces every enable and status flag low regardless of the current state.
  always_comb begin
    bus.w_pc_we      = pc_we   && !w_rst;
    bus.w_ir_we      = ir_we   && !w_rst;
    bus.w_rf_we      = rf_we   && !w_rst;
    bus.w_mem_req    = mem_req && !w_rst;
    bus.w_mem_we     = mem_we  && !w_rst;
    bus.w_imm_src    = imm_src;
    bus.w_alu_src_a  = alu_src_a;
    bus.w_alu_src_b  = alu_src_b;
    bus.w_alu_op     = alu_op;
    bus.w_result_src = result_src;
    bus.w_state      = state_q;
    bus.w_halt       = (state_q == ST_HALT) && !w_rst;
    bus.w_err        = err_q && !w_rst;
    bus.w_retire_cnt = retire_cnt_q;
  end

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Randomized instruction-stream bench for m_mc_ctrl against a per-instruction state-list model.
// Latency: checks every cycle at negedge+1.
// Backpressure: memory ack delay is randomized, including past the timeout limit.
module tb_m_mc_ctrl;

  localparam logic [6:0] C_OP     = 7'b0110011;
  localparam logic [6:0] C_OP_IMM = 7'b0010011;
  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam int         TMO      = 15;
  localparam int         HREG     = 30;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  always #5 w_clk = ~w_clk;

  m_mc_ctrl_if bus ();

  m_mc_ctrl #(.MEM_TIMEOUT(TMO), .HALT_REG(HREG)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_retire = 32'd0;
  bit          halted     = 1'b0;
  bit          exp_err    = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected control word {pc,ir,rf,req,we,imm,a,b,op,res} for a state, from the state table.
  function automatic logic [14:0] exp_ctrl(input int st, input logic [6:0] op, input logic tk);
    logic [1:0] imm;
    case (st)
      0:  return {5'b11000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10};
      1: begin
        imm = (op == C_OP_IMM) ? 2'b00 : (op == C_STORE) ? 2'b01 : (op == C_BRANCH) ? 2'b10 : 2'b11;
        return {5'b00000, imm, 2'b10, 2'b01, 2'b00, 2'b00};
      end
      2:  return {5'b00000, (op == C_STORE) ? 2'b01 : 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
      3:  return {5'b00010, 10'b0};
      4:  return {5'b00100, 8'b0, 2'b01};
      5:  return {5'b00011, 10'b0};
      6:  return {5'b00000, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
      7:  return {5'b00000, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
      8:  return {5'b00100, 10'b0};
      9:  return {tk, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
      10: return {5'b10000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
      default: return 15'b0;
    endcase
  endfunction

  function automatic logic [14:0] act_ctrl();
    return {bus.w_pc_we, bus.w_ir_we, bus.w_rf_we, bus.w_mem_req, bus.w_mem_we,
            bus.w_imm_src, bus.w_alu_src_a, bus.w_alu_src_b, bus.w_alu_op, bus.w_result_src};
  endfunction

  // Tasks start and end at a negedge instant.
  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      w_rst = 1'b1;
      bus.w_mem_ack = 1'($urandom_range(0, 1));
      bus.w_branch_taken = 1'($urandom_range(0, 1));
      #1;
      check("rst_enables", 32'({bus.w_pc_we, bus.w_ir_we, bus.w_rf_we, bus.w_mem_req, bus.w_mem_we}), 32'd0);
      check("rst_halt_err", 32'({bus.w_halt, bus.w_err}), 32'd0);
      @(negedge w_clk);
    end
    w_rst = 1'b0;
    bus.w_mem_ack = 1'b0;
    exp_retire = 32'd0;
    halted = 1'b0;
    exp_err = 1'b0;
  endtask

  // Run one instruction: the model lists the states it must visit, cycle by cycle.
  // stop_at >= 0 abandons the instruction after that many cycles (for mid-flight reset).
  task automatic run_instr(input logic [6:0] op, input logic [4:0] rd, input logic tk,
                           input int wait_n, input int stop_at);
    int  seq[$];
    int  ack_idx = -1;
    bit  retires = 1'b0;
    bit  to_halt = 1'b0;
    bit  err     = 1'b0;
    int  mst;
    int  n;
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      C_OP_IMM, C_OP: begin
        seq.push_back((op == C_OP) ? 6 : 7);
        seq.push_back(8);
        retires = 1'b1;
        to_halt = (rd == 5'(HREG));
      end
      C_LOAD, C_STORE: begin
        seq.push_back(2);
        mst = (op == C_LOAD) ? 3 : 5;
        if (wait_n + 1 <= TMO) begin
          repeat (wait_n + 1) seq.push_back(mst);
          ack_idx = seq.size() - 1;
          retires = 1'b1;
          if (op == C_LOAD) begin
            seq.push_back(4);
            to_halt = (rd == 5'(HREG));
          end
        end else begin
          repeat (TMO) seq.push_back(mst);
          to_halt = 1'b1;
          err = 1'b1;
        end
      end
      C_BRANCH: begin
        seq.push_back(9);
        retires = 1'b1;
      end
      C_JAL: begin
        seq.push_back(10);
        seq.push_back(8);
        retires = 1'b1;
        to_halt = (rd == 5'(HREG));
      end
      default: begin
        to_halt = 1'b1;
        err = 1'b1;
      end
    endcase
    n = (stop_at >= 0 && stop_at < seq.size()) ? stop_at : seq.size();
    for (int i = 0; i < n; i++) begin
      bus.w_opcode = op;
      bus.w_rd = rd;
      bus.w_branch_taken = tk;
      bus.w_mem_ack = (i == ack_idx);
      #1;
      check($sformatf("state[%0d] op%0h", i, op), 32'(bus.w_state), 32'(seq[i]));
      check($sformatf("ctrl st%0d", seq[i]), 32'(act_ctrl()), 32'(exp_ctrl(seq[i], op, tk)));
      check("halt_err_run", 32'({bus.w_halt, bus.w_err}), 32'd0);
      check("retire_run", bus.w_retire_cnt, exp_retire);
      @(negedge w_clk);
    end
    bus.w_mem_ack = 1'b0;
    if (stop_at < 0) begin
      if (retires) exp_retire = exp_retire + 32'd1;
      if (to_halt) begin
        halted = 1'b1;
        exp_err = err;
      end
    end
  endtask

  task automatic check_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.w_mem_ack = 1'($urandom_range(0, 1));
      bus.w_opcode = 7'($urandom);
      bus.w_rd = 5'($urandom);
      bus.w_branch_taken = 1'($urandom_range(0, 1));
      #1;
      check("halt_state", 32'(bus.w_state), 32'd15);
      check("halt_ctrl", 32'({bus.w_pc_we, bus.w_ir_we, bus.w_rf_we, bus.w_mem_req, bus.w_mem_we}), 32'd0);
      check("halt_flags", 32'({bus.w_halt, bus.w_err}), 32'({1'b1, exp_err}));
      check("halt_retire", bus.w_retire_cnt, exp_retire);
      @(negedge w_clk);
    end
    bus.w_mem_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops[7];
    ops[0] = C_OP;     ops[1] = C_OP_IMM; ops[2] = C_LOAD; ops[3] = C_STORE;
    ops[4] = C_BRANCH; ops[5] = C_JAL;    ops[6] = 7'b0000000;
    bus.w_opcode = 7'd0;
    bus.w_rd = 5'd0;
    bus.w_branch_taken = 1'b0;
    bus.w_mem_ack = 1'b0;
    @(negedge w_clk);
    do_reset(2);

    // Directed cases.
    run_instr(C_OP_IMM, 5'd1, 1'b0, 0, -1);
    check("retire_after_addi", bus.w_retire_cnt, 32'd1);
    run_instr(C_LOAD, 5'd5, 1'b0, 3, -1);
    run_instr(C_BRANCH, 5'd0, 1'b1, 0, -1);
    run_instr(C_BRANCH, 5'd0, 1'b0, 0, -1);
    run_instr(C_OP, 5'd3, 1'b0, 0, -1);
    run_instr(C_JAL, 5'd1, 1'b0, 0, -1);
    run_instr(C_STORE, 5'd0, 1'b0, TMO - 1, -1);
    run_instr(C_STORE, 5'd0, 1'b0, 40, -1);
    check_halt(4);
    do_reset(1);
    run_instr(C_OP_IMM, 5'd30, 1'b0, 0, -1);
    check_halt(3);
    do_reset(1);
    run_instr(7'b0000000, 5'd0, 1'b0, 0, -1);
    check_halt(2);
    do_reset(1);
    run_instr(C_OP_IMM, 5'd2, 1'b0, 0, -1);
    run_instr(C_LOAD, 5'd4, 1'b0, 10, 5);
    do_reset(1);
    run_instr(C_LOAD, 5'd4, 1'b0, TMO - 1, -1);
    run_instr(C_LOAD, 5'd30, 1'b0, 0, -1);
    check_halt(2);
    do_reset(1);

    // Randomized instruction stream.
    for (int k = 0; k < 80; k++) begin
      int sel;
      int w;
      sel = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(0, 5));
      w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(12, 18)) : int'($urandom_range(0, 4));
      run_instr(ops[sel], 5'($urandom), 1'($urandom_range(0, 1)), w, -1);
      if (halted) begin
        check_halt(2);
        do_reset(int'($urandom_range(1, 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
